// File: rtl/uart_frame_scheduler_pkg.sv
// Shared types and constants for the UART frame scheduler.
// Frame lengths are provided both with and without the trailing checksum
// byte; the top selects between them via UART_SCHED_CHECKSUM_EN.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_WAIT = 2'd3
  } state_e;

  typedef enum logic {
    FT_POS  = 1'b0,
    FT_FIRE = 1'b1
  } frame_e;

  localparam logic [7:0] HDR_POS_DEFAULT  = 8'hA5;
  localparam logic [7:0] HDR_FIRE_DEFAULT = 8'h5A;

  localparam int IDX_W = 3;

  localparam logic [IDX_W-1:0] POS_LEN_CK    = 3'd5;
  localparam logic [IDX_W-1:0] POS_LEN_NOCK  = 3'd4;
  localparam logic [IDX_W-1:0] FIRE_LEN_CK   = 3'd3;
  localparam logic [IDX_W-1:0] FIRE_LEN_NOCK = 3'd2;

  // Byte idx of a frame built from the given snapshot. The checksum slot
  // (XOR of all preceding bytes) is always computable; whether it is sent
  // depends only on the frame length chosen by the caller.
  function automatic logic [7:0] frame_byte(
    input frame_e           ft,
    input logic [IDX_W-1:0] idx,
    input logic [7:0]       hdr_pos,
    input logic [7:0]       hdr_fire,
    input logic [9:0]       x,
    input logic [9:0]       y,
    input logic [1:0]       dir
  );
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] res;
    res = 8'h00;
    if (ft == FT_FIRE) begin
      b0 = hdr_fire;
      b1 = {6'b000000, dir};
      case (idx)
        3'd0:    res = b0;
        3'd1:    res = b1;
        3'd2:    res = b0 ^ b1;
        default: res = 8'h00;
      endcase
    end else begin
      b0 = hdr_pos;
      b1 = x[7:0];
      b2 = y[7:0];
      b3 = {2'b00, dir, y[9:8], x[9:8]};
      case (idx)
        3'd0:    res = b0;
        3'd1:    res = b1;
        3'd2:    res = b2;
        3'd3:    res = b3;
        3'd4:    res = b0 ^ b1 ^ b2 ^ b3;
        default: res = 8'h00;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_frame_scheduler_if.sv
// Byte handshake between the frame scheduler (master) and the UART
// transmitter (slave): tx_start/tx_data out, tx_done back.
interface uart_frame_scheduler_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;

  modport master (output tx_start, output tx_data, input tx_done);
  modport slave  (input tx_start, input tx_data, output tx_done);
endinterface

// File: rtl/uart_frame_scheduler_edge_rise.sv
// Registered rising-edge detector: o_rise is high in the cycle where i_sig
// is high and its previous sampled value was low.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;

  // Remember last cycle's level
  always_ff @(posedge clk) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= i_sig;
  end

  assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/uart_frame_scheduler.sv
// uart_frame_scheduler: arbitrates the UART transmitter between periodic
// position frames (every FRAME_DIV-th vsync edge) and fire-event frames.
// Fire frames win when both are pending; requests coalesce while pending.
// Optional feature macro: UART_SCHED_CHECKSUM_EN appends an XOR checksum
// byte to every frame (pos 5 bytes, fire 3) instead of (pos 4, fire 2).
module uart_frame_scheduler
  import uart_frame_pkg::*;
#(
  parameter int unsigned FRAME_DIV = 1,
  parameter logic [7:0]  HDR_POS   = HDR_POS_DEFAULT,
  parameter logic [7:0]  HDR_FIRE  = HDR_FIRE_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_select_mode,
  input  logic                          i_vsync,
  input  logic                          i_fire,
  input  logic [9:0]                    i_xpos,
  input  logic [9:0]                    i_ypos,
  input  logic [1:0]                    i_direction_bullet,
  uart_frame_scheduler_if.master        tx_if,
  output logic                          o_busy,
  output logic                          o_frame_sent
);

  localparam logic [1:0] ST_IDLE = S_IDLE;
  localparam logic [1:0] ST_LOAD = S_LOAD;
  localparam logic [1:0] ST_SEND = S_SEND;
  localparam logic [1:0] ST_WAIT = S_WAIT;

`ifdef UART_SCHED_CHECKSUM_EN
  localparam logic [IDX_W-1:0] POS_LEN  = POS_LEN_CK;
  localparam logic [IDX_W-1:0] FIRE_LEN = FIRE_LEN_CK;
`else
  localparam logic [IDX_W-1:0] POS_LEN  = POS_LEN_NOCK;
  localparam logic [IDX_W-1:0] FIRE_LEN = FIRE_LEN_NOCK;
`endif

  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

  logic [1:0]       r_state;
  frame_e           r_ftype;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_tx_data;
  logic             r_frame_sent;
  logic             r_pos_pend;
  logic             r_fire_pend;
  logic [7:0]       r_div;
  logic [9:0]       r_x;
  logic [9:0]       r_y;
  logic [1:0]       r_dir;

  logic             w_vs_rise;
  logic             w_fire_rise;
  logic             w_start_fire;
  logic             w_start_pos;
  logic [IDX_W-1:0] w_len;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_last;

  edge_rise u_vs_edge (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (i_vsync),
    .o_rise (w_vs_rise)
  );

  edge_rise u_fire_edge (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (i_fire),
    .o_rise (w_fire_rise)
  );

  // Requests are only granted in multiplayer mode; fire beats position.
  assign w_start_fire = (r_state == ST_IDLE) && i_select_mode && r_fire_pend;
  assign w_start_pos  = (r_state == ST_IDLE) && i_select_mode && !r_fire_pend && r_pos_pend;

  assign w_len     = (r_ftype == FT_FIRE) ? FIRE_LEN : POS_LEN;
  assign w_idx_nxt = r_idx + 1'b1;
  assign w_last    = (r_idx == (w_len - 1'b1));

  // Vsync divider and pending request flags. A grant clears its flag
  // before a same-cycle edge is applied, so that edge is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div       <= 8'h00;
      r_pos_pend  <= 1'b0;
      r_fire_pend <= 1'b0;
    end else if (!i_select_mode) begin
      r_div       <= 8'h00;
      r_pos_pend  <= 1'b0;
      r_fire_pend <= 1'b0;
    end else begin
      if (w_start_fire) r_fire_pend <= 1'b0;
      if (w_start_pos)  r_pos_pend  <= 1'b0;
      if (w_vs_rise) begin
        if (r_div == DIV_LAST) begin
          r_div      <= 8'h00;
          r_pos_pend <= 1'b1;
        end else begin
          r_div <= r_div + 8'd1;
        end
      end
      if (w_fire_rise) r_fire_pend <= 1'b1;
    end
  end

  // Frame sequencer: IDLE -> LOAD -> SEND -> WAIT -> (SEND | IDLE).
  // tx_data is loaded on the transition into SEND so it is valid together
  // with tx_start and held through WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ftype      <= FT_POS;
      r_idx        <= '0;
      r_tx_data    <= 8'h00;
      r_frame_sent <= 1'b0;
    end else begin
      r_frame_sent <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_fire) begin
            r_ftype <= FT_FIRE;
            r_state <= ST_LOAD;
          end else if (w_start_pos) begin
            r_ftype <= FT_POS;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_idx     <= '0;
          r_tx_data <= frame_byte(r_ftype, '0, HDR_POS, HDR_FIRE,
                                  i_xpos, i_ypos, i_direction_bullet);
          r_state   <= ST_SEND;
        end
        ST_SEND: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tx_if.tx_done) begin
            if (w_last) begin
              r_state      <= ST_IDLE;
              r_frame_sent <= 1'b1;
            end else begin
              r_idx     <= w_idx_nxt;
              r_tx_data <= frame_byte(r_ftype, w_idx_nxt, HDR_POS, HDR_FIRE,
                                      r_x, r_y, r_dir);
              r_state   <= ST_SEND;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Position/direction snapshot taken once per frame in LOAD
  always_ff @(posedge clk) begin
    if (r_state == ST_LOAD) begin
      r_x   <= i_xpos;
      r_y   <= i_ypos;
      r_dir <= i_direction_bullet;
    end
  end

  assign tx_if.tx_start = (r_state == ST_SEND);
  assign tx_if.tx_data  = r_tx_data;
  assign o_busy         = (r_state != ST_IDLE);
  assign o_frame_sent   = r_frame_sent;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Scoreboard bench for uart_frame_scheduler. A frame-level reference model
// pushes expected bytes and per-cycle expectations; a monitor compares.
module tb_uart_frame_scheduler;
  import uart_frame_pkg::*;

  localparam int FD = 3;
`ifdef UART_SCHED_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  localparam int PL = CK ? 5 : 4;
  localparam int FL = CK ? 3 : 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       vs  = 1'b0;
  logic       fi  = 1'b0;
  logic [9:0] x   = '0;
  logic [9:0] y   = '0;
  logic [1:0] dir = '0;
  logic       busy;
  logic       fs;

  uart_frame_scheduler_if tx_if();

  uart_frame_scheduler #(.FRAME_DIV(FD)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_select_mode      (sel),
    .i_vsync            (vs),
    .i_fire             (fi),
    .i_xpos             (x),
    .i_ypos             (y),
    .i_direction_bullet (dir),
    .tx_if              (tx_if.master),
    .o_busy             (busy),
    .o_frame_sent       (fs)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] exp_q[$];
  logic [7:0] sent_q[$];
  bit m_pv, m_pf, m_pp, m_fp, m_active, m_load, m_wait, m_insend, m_fire_sel;
  int m_div, m_left;
  logic m_exp_start = 1'b0, m_exp_fs = 1'b0, m_busy = 1'b0;

  task automatic push_frame(input bit is_fire);
    logic [7:0] b[$];
    logic [7:0] cs;
    if (is_fire) begin
      b.push_back(8'h5A);
      b.push_back({6'd0, dir});
    end else begin
      b.push_back(8'hA5);
      b.push_back(x % 256);
      b.push_back(y % 256);
      b.push_back(dir * 16 + (y / 256) * 4 + (x / 256));
    end
    cs = 8'h00;
    foreach (b[i]) cs = cs ^ b[i];
    if (CK) b.push_back(cs);
    foreach (b[i]) exp_q.push_back(b[i]);
    m_left = b.size();
  endtask

  always @(posedge clk) begin
    bit vr, fr, was_send;
    if (rst) begin
      m_pv = 0; m_pf = 0; m_pp = 0; m_fp = 0; m_div = 0;
      m_active = 0; m_load = 0; m_wait = 0; m_insend = 0; m_left = 0;
      exp_q.delete();
      m_exp_start = 0; m_exp_fs = 0; m_busy = 0;
    end else begin
      vr = vs && !m_pv;
      fr = fi && !m_pf;
      m_pv = vs;
      m_pf = fi;
      was_send = m_insend;
      m_exp_start = 0;
      m_exp_fs = 0;
      if (m_active) begin
        if (m_load) begin
          m_load = 0;
          push_frame(m_fire_sel);
          m_exp_start = 1;
        end else if (was_send) begin
          m_wait = 1;
        end else if (m_wait && tx_if.tx_done) begin
          m_wait = 0;
          m_left--;
          if (m_left == 0) begin
            m_active = 0;
            m_exp_fs = 1;
          end else begin
            m_exp_start = 1;
          end
        end
      end else if (sel && (m_fp || m_pp)) begin
        m_active = 1;
        m_load = 1;
        m_fire_sel = m_fp;
        if (m_fp) m_fp = 0;
        else      m_pp = 0;
      end
      if (!sel) begin
        m_pp = 0; m_fp = 0; m_div = 0;
      end else begin
        if (vr) begin
          if (m_div == FD - 1) begin m_div = 0; m_pp = 1; end
          else m_div++;
        end
        if (fr) m_fp = 1;
      end
      m_insend = m_exp_start;
      m_busy = m_active;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    chk("tx_start", tx_if.tx_start, m_exp_start);
    chk("busy", busy, m_busy);
    chk("frame_sent", fs, m_exp_fs);
    if (tx_if.tx_start === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_data: got %0h expected no byte", tx_if.tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_if.tx_data !== e) begin
          errors++;
          $display("FAIL tx_data: got %0h expected %0h", tx_if.tx_data, e);
        end
      end
      sent_q.push_back(tx_if.tx_data);
    end
  end

  // ---------------- UART responder ----------------
  initial begin
    int cd;
    cd = 0;
    tx_if.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_if.tx_done = 1'b0;
      if (rst) cd = 0;
      else if (cd > 0) begin
        cd--;
        if (cd == 0) tx_if.tx_done = 1'b1;
      end else if (!busy && $urandom_range(0, 5) == 0) begin
        tx_if.tx_done = 1'b1;
      end
      if (tx_if.tx_start === 1'b1) cd = $urandom_range(1, 4);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_vs();
    vs = 1'b1; cyc(1); vs = 1'b0; cyc(2);
  endtask

  task automatic wait_idle(input string nm);
    int quiet;
    int k;
    quiet = 0;
    k = 0;
    while (quiet < 6 && k < 3000) begin
      @(negedge clk);
      k++;
      if (!busy && exp_q.size() == 0 && !m_pp && !m_fp) quiet++;
      else quiet = 0;
    end
    if (quiet < 6) begin
      checks++;
      errors++;
      $display("FAIL %s: got busy after %0d cycles, required idle", nm, k);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; vs = 1'b0; fi = 1'b0;
    cyc(3);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] e_pos[5];
    logic [7:0] e_fire[3];
    int n;
    e_pos  = '{8'hA5, 8'h2C, 8'hBC, 8'h19, 8'h2C};
    e_fire = '{8'h5A, 8'h03, 8'h59};

    // Reset state
    rst = 1'b1;
    cyc(3);
    chk("rst_tx_data", tx_if.tx_data, 8'h00);
    chk("rst_tx_start", tx_if.tx_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_sent", fs, 1'b0);
    rst = 1'b0;
    cyc(2);

    // Position frame on the FD-th vsync edge, with latency check
    sel = 1'b1; x = 10'd300; y = 10'd700; dir = 2'd1;
    sent_q.delete();
    pulse_vs();
    pulse_vs();
    vs = 1'b1;
    cyc(1);
    vs = 1'b0;
    cyc(1);
    chk("lat_k2_start", tx_if.tx_start, 1'b0);
    cyc(1);
    chk("lat_k3_start", tx_if.tx_start, 1'b1);
    wait_idle("pos_frame");
    chk("pos_len", sent_q.size(), PL);
    for (int i = 0; i < PL && i < sent_q.size(); i++) chk("pos_byte", sent_q[i], e_pos[i]);

    // Fire frame
    dir = 2'd3;
    sent_q.delete();
    fi = 1'b1; cyc(1); fi = 1'b0;
    wait_idle("fire_frame");
    chk("fire_len", sent_q.size(), FL);
    for (int i = 0; i < FL && i < sent_q.size(); i++) chk("fire_byte", sent_q[i], e_fire[i]);

    // Simultaneous fire and (dividing) vsync edge
    x = 10'($urandom); y = 10'($urandom); dir = 2'($urandom);
    pulse_vs();
    pulse_vs();
    sent_q.delete();
    vs = 1'b1; fi = 1'b1; cyc(1); vs = 1'b0; fi = 1'b0;
    wait_idle("simul");
    chk("simul_len", sent_q.size(), FL + PL);
    if (sent_q.size() == FL + PL) begin
      chk("simul_first_hdr", sent_q[0], 8'h5A);
      chk("simul_second_hdr", sent_q[FL], 8'hA5);
    end

    // Divider: 7 vsync edges with FD=3 gives two frames
    do_reset();
    sent_q.delete();
    for (int i = 0; i < 7; i++) begin
      pulse_vs();
      cyc(12);
    end
    wait_idle("div");
    n = 0;
    foreach (sent_q[i]) if (sent_q[i] == 8'hA5) n++;
    chk("div_frames", n, 2);
    chk("div_bytes", sent_q.size(), 2 * PL);

    // select_mode low: edges ignored
    sel = 1'b0;
    sent_q.delete();
    for (int i = 0; i < 4; i++) pulse_vs();
    fi = 1'b1; cyc(1); fi = 1'b0;
    cyc(10);
    chk("nosel_bytes", sent_q.size(), 0);

    // Dropping select_mode mid-frame lets the frame finish
    sel = 1'b1;
    fi = 1'b1; cyc(1); fi = 1'b0;
    n = 0;
    while (sent_q.size() == 0 && n < 50) begin cyc(1); n++; end
    sel = 1'b0;
    wait_idle("sel_drop");
    chk("sel_drop_len", sent_q.size(), FL);
    sel = 1'b1;

    // Reset during WAIT of byte 2
    sent_q.delete();
    fi = 1'b1; cyc(1); fi = 1'b0;
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      #1;
      n++;
      if (sent_q.size() >= 2) break;
    end
    chk("rst_mid_seen2", sent_q.size(), 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rstmid_tx_start", tx_if.tx_start, 1'b0);
    chk("rstmid_tx_data", tx_if.tx_data, 8'h00);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_fs", fs, 1'b0);
    rst = 1'b0;
    cyc(20);
    chk("rstmid_no_more", sent_q.size(), 2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      sel = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 5) == 0) vs = ~vs;
      fi  = ($urandom_range(0, 19) == 0);
      x   = 10'($urandom);
      y   = 10'($urandom);
      dir = 2'($urandom);
      rst = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    rst = 1'b0; sel = 1'b1; vs = 1'b0; fi = 1'b0;
    wait_idle("random");
    chk("random_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
